// File: rtl/bf_stage_sequencer.sv
// Frame-level launch scheduler for one butterfly/CBFP stage: gates frame admission on
// index-set availability and capacity, drives the fixed-length valid window, tracks frames in flight.
module bf_stage_sequencer #(
  parameter int unsigned FRAME_LEN    = 32,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned MAX_INFLIGHT = 1,
  parameter int unsigned IDX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        frame_req,
  input  logic        idx1_valid,
  input  logic        idx2_valid,
  input  logic        stage_out_en,
  input  logic        err_clr,
  output logic        frame_ack,
  output logic        stage_valid,
  output logic        busy,
  output logic [1:0]  inflight,
  output logic [2:0]  idx1_pend,
  output logic [2:0]  idx2_pend,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_idx_ovf,
  output logic        err_spurious
);

  localparam int unsigned     CW     = $clog2(FRAME_LEN + GAP_CYCLES + 1);
  localparam logic [2:0]      DEPTH  = 3'(IDX_DEPTH);
  localparam logic [1:0]      MAXI   = 2'(MAX_INFLIGHT);
  localparam logic [CW-1:0]   LAST_S = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]   LAST_G = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_STREAM, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_soe_d;
  logic          w_ack_cyc, w_launch, w_done_ok, w_spur_ev;
  logic [3:0]    w_p1, w_p2;
  logic [1:0]    w_infl_nxt;
  logic          w_ack_nxt, w_valid_nxt, w_busy_nxt;

  // Returns {overflow, next count}; a pulse coinciding with the ACK decrement cancels out.
  function automatic logic [3:0] pend_next(input logic [2:0] p, input logic pulse, input logic ack);
    logic [3:0] res;
    res = {1'b0, p};
    if (pulse && !ack) begin
      if (p == DEPTH) res = {1'b1, p};
      else            res = {1'b0, p + 3'd1};
    end else if (ack && !pulse && p != 3'd0) begin
      res = {1'b0, p - 3'd1};
    end
    return res;
  endfunction

  assign w_ack_cyc = (r_state == S_ACK);
  assign w_launch  = en && frame_req && (idx1_pend != 3'd0) && (idx2_pend != 3'd0) &&
                     (inflight < MAXI);
  assign w_done_ok = frame_done && (inflight != 2'd0);
  assign w_spur_ev = frame_done && (inflight == 2'd0);
  assign w_p1      = pend_next(idx1_pend, idx1_valid, w_ack_cyc);
  assign w_p2      = pend_next(idx2_pend, idx2_valid, w_ack_cyc);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE:   if (w_launch) w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_STREAM;
      S_STREAM: if (r_cnt == LAST_S) w_state_nxt = S_GAP;
                else                 w_cnt_nxt   = r_cnt + 1'b1;
      S_GAP:    if (r_cnt == LAST_G) w_state_nxt = S_IDLE;
                else                 w_cnt_nxt   = r_cnt + 1'b1;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_infl_nxt = inflight;
    case ({w_ack_cyc, w_done_ok})
      2'b10:   w_infl_nxt = inflight + 2'd1;
      2'b01:   w_infl_nxt = inflight - 2'd1;
      default: w_infl_nxt = inflight;
    endcase
    // Outputs are registered from the next state so they align with the state register.
    w_ack_nxt   = (w_state_nxt == S_ACK);
    w_valid_nxt = (w_state_nxt == S_STREAM);
    w_busy_nxt  = (w_state_nxt != S_IDLE) || (w_infl_nxt != 2'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_soe_d      <= 1'b0;
      frame_ack    <= 1'b0;
      stage_valid  <= 1'b0;
      busy         <= 1'b0;
      inflight     <= '0;
      idx1_pend    <= '0;
      idx2_pend    <= '0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      err_idx_ovf  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_soe_d      <= stage_out_en;
      frame_done   <= r_soe_d & ~stage_out_en;
      frame_ack    <= w_ack_nxt;
      stage_valid  <= w_valid_nxt;
      busy         <= w_busy_nxt;
      inflight     <= w_infl_nxt;
      idx1_pend    <= w_p1[2:0];
      idx2_pend    <= w_p2[2:0];
      frame_cnt    <= frame_cnt + 16'(w_done_ok);
      err_idx_ovf  <= w_p1[3] | w_p2[3] | (err_idx_ovf & ~err_clr);
      err_spurious <= w_spur_ev | (err_spurious & ~err_clr);
    end
  end

endmodule

// File: tb/tb_bf_stage_sequencer.sv
// Randomized bench: two sequencers (capacity 1 and 2) share upstream stimulus and are
// compared every cycle against a timeline-based reference model.
module tb_bf_stage_sequencer;

  localparam int FL    = 32;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, en, frame_req, idx1_valid, idx2_valid, err_clr;
  logic soe [2];
  logic ack_w [2], valid_w [2], busy_w [2], done_w [2], ovf_w [2], spur_w [2];
  logic [1:0]  infl_w [2];
  logic [2:0]  p1_w [2], p2_w [2];
  logic [15:0] cnt_w [2];

  bf_stage_sequencer #(.FRAME_LEN(FL), .GAP_CYCLES(GAP), .MAX_INFLIGHT(1), .IDX_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rstn(rstn), .en(en), .frame_req(frame_req), .idx1_valid(idx1_valid),
    .idx2_valid(idx2_valid), .stage_out_en(soe[0]), .err_clr(err_clr),
    .frame_ack(ack_w[0]), .stage_valid(valid_w[0]), .busy(busy_w[0]), .inflight(infl_w[0]),
    .idx1_pend(p1_w[0]), .idx2_pend(p2_w[0]), .frame_done(done_w[0]), .frame_cnt(cnt_w[0]),
    .err_idx_ovf(ovf_w[0]), .err_spurious(spur_w[0]));

  bf_stage_sequencer #(.FRAME_LEN(FL), .GAP_CYCLES(GAP), .MAX_INFLIGHT(2), .IDX_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rstn(rstn), .en(en), .frame_req(frame_req), .idx1_valid(idx1_valid),
    .idx2_valid(idx2_valid), .stage_out_en(soe[1]), .err_clr(err_clr),
    .frame_ack(ack_w[1]), .stage_valid(valid_w[1]), .busy(busy_w[1]), .inflight(infl_w[1]),
    .idx1_pend(p1_w[1]), .idx2_pend(p2_w[1]), .frame_done(done_w[1]), .frame_cnt(cnt_w[1]),
    .err_idx_ovf(ovf_w[1]), .err_spurious(spur_w[1]));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: t0 is the cycle the current frame's launch was decided; all window
  // timing is derived arithmetically from it.
  int t0 [2], m_infl [2], m_p1 [2], m_p2 [2], m_cnt [2];
  bit m_ack [2], m_valid [2], m_busy [2], m_done [2], m_ovf [2], m_spur [2], m_soep [2];
  int bl [2], bstart [2];
  int cyc = 0;
  bit rst_done = 0;

  function automatic int maxv(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit idle(input int i, input int k);
    return (k - t0[i]) >= (FL + GAP + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t0[i] = -1000; m_infl[i] = 0; m_p1[i] = 0; m_p2[i] = 0; m_cnt[i] = 0;
      m_ack[i] = 0; m_valid[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
      m_spur[i] = 0; m_soep[i] = 0; bl[i] = 0; bstart[i] = -1;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("frame_ack%0d", i),    ack_w[i],   m_ack[i]);
      check($sformatf("stage_valid%0d", i),  valid_w[i], m_valid[i]);
      check($sformatf("busy%0d", i),         busy_w[i],  m_busy[i]);
      check($sformatf("inflight%0d", i),     infl_w[i],  m_infl[i]);
      check($sformatf("idx1_pend%0d", i),    p1_w[i],    m_p1[i]);
      check($sformatf("idx2_pend%0d", i),    p2_w[i],    m_p2[i]);
      check($sformatf("frame_done%0d", i),   done_w[i],  m_done[i]);
      check($sformatf("frame_cnt%0d", i),    cnt_w[i],   m_cnt[i]);
      check($sformatf("err_idx_ovf%0d", i),  ovf_w[i],   m_ovf[i]);
      check($sformatf("err_spurious%0d", i), spur_w[i],  m_spur[i]);
    end
  endtask

  task automatic drive_zero();
    en = 0; frame_req = 0; idx1_valid = 0; idx2_valid = 0; err_clr = 0;
    soe[0] = 0; soe[1] = 0;
  endtask

  task automatic step_model(input int i);
    bit ackc, launch, ov, ok, spev;
    int np1, np2, ninfl;
    ackc   = m_ack[i];
    launch = idle(i, cyc) && en && frame_req && m_p1[i] > 0 && m_p2[i] > 0 && m_infl[i] < maxv(i);
    ov  = 0;
    np1 = m_p1[i] + int'(idx1_valid) - int'(ackc);
    np2 = m_p2[i] + int'(idx2_valid) - int'(ackc);
    if (idx1_valid && !ackc && m_p1[i] == DEPTH) begin np1 = m_p1[i]; ov = 1; end
    if (idx2_valid && !ackc && m_p2[i] == DEPTH) begin np2 = m_p2[i]; ov = 1; end
    ok    = m_done[i] && m_infl[i] > 0;
    spev  = m_done[i] && m_infl[i] == 0;
    ninfl = m_infl[i] + int'(ackc) - int'(ok);
    m_cnt[i]  = (m_cnt[i] + int'(ok)) % 65536;
    m_ovf[i]  = ov || (m_ovf[i] && !err_clr);
    m_spur[i] = spev || (m_spur[i] && !err_clr);
    m_done[i] = m_soep[i] && !soe[i];
    m_soep[i] = soe[i];
    if (launch) t0[i] = cyc;
    m_p1[i] = np1; m_p2[i] = np2; m_infl[i] = ninfl;
    m_ack[i]   = (cyc + 1) == (t0[i] + 1);
    m_valid[i] = ((cyc + 1 - t0[i]) >= 2) && ((cyc + 1 - t0[i]) <= FL + 1);
    m_busy[i]  = !idle(i, cyc + 1) || ninfl != 0;
  endtask

  initial begin
    bit phase_a, quiet;
    rstn = 1'b1;
    drive_zero();
    model_reset();
    #2 rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      compare_all();
    end
    rstn = 1'b1;

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      cyc++;
      if (!rst_done && cyc > 2000 && m_valid[0] && (cyc - t0[0]) == 12) begin
        rstn = 1'b0;
        drive_zero();
        model_reset();
        #1;
        compare_all();
        rst_done = 1;
        @(negedge clk);
        cyc++;
        rstn = 1'b1;
      end
      compare_all();

      phase_a = (cyc < 150);
      quiet   = (cyc >= 400) && ((cyc % 400) >= 340);
      en         = phase_a ? 1'b1 : ($urandom % 16 != 0);
      frame_req  = quiet ? 1'b0 : (phase_a ? 1'b1 : ($urandom % 8 != 0));
      idx1_valid = phase_a ? ($urandom % 4 == 0) : ($urandom % 12 == 0);
      idx2_valid = (cyc == 150) ? 1'b1 : (phase_a ? 1'b0 : ($urandom % 12 == 0));
      err_clr    = (cyc % 97 == 0);

      // Emulated stage: output burst of FL+1 cycles starting 3 cycles after each ack.
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i]) bstart[i] = cyc + 3;
        if (bl[i] > 0) begin
          soe[i] = 1'b1; bl[i]--;
        end else if (bstart[i] != -1 && bstart[i] <= cyc) begin
          soe[i] = 1'b1; bl[i] = FL; bstart[i] = -1;
        end else if (quiet && (cyc % 400) == 380 && m_infl[i] == 0 && bstart[i] == -1) begin
          soe[i] = 1'b1; bl[i] = 1;
        end else begin
          soe[i] = 1'b0;
        end
      end

      for (int i = 0; i < 2; i++) step_model(i);
    end

    check("reset_mid_stream_hit", rst_done, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
